// File: rtl/relu_maxpool1d_if.sv
// AXI-Stream bundle used on both sides of the ReLU + 1-D max-pool stage.
interface relu_maxpool1d_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;
    logic                    tvalid;
    logic                    tready;

    modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/relu_maxpool1d.sv
// ReLU followed by non-overlapping 1-D max-pooling over POOL samples, with frame
// boundaries carried through TLAST and a partial trailing window flushed.
module relu_maxpool1d #(
    parameter int DATA_WIDTH = 16,
    parameter int POOL       = 2,
    parameter int RELU_EN    = 1
) (
    input  logic              AXIS_ACLK,
    input  logic              AXIS_ARESET,
    relu_maxpool1d_if.slave   s_axis,
    relu_maxpool1d_if.master  m_axis
);
    localparam int CW = (POOL > 1) ? $clog2(POOL) : 1;

    logic [CW-1:0]                cnt;
    logic signed [DATA_WIDTH-1:0] acc;
    logic signed [DATA_WIDTH-1:0] x;
    logic signed [DATA_WIDTH-1:0] r;
    logic signed [DATA_WIDTH-1:0] m;
    logic [DATA_WIDTH-1:0]        out_data;
    logic                         out_last;
    logic                         out_valid;
    logic                         in_fire;
    logic                         close;
    logic                         unused_keep;

    // Input is taken whenever the single output slot is free or draining this edge.
    assign s_axis.tready = !out_valid || m_axis.tready;
    assign in_fire       = s_axis.tvalid && s_axis.tready;
    assign unused_keep   = ^s_axis.tkeep;

    always_comb begin
        x = s_axis.tdata;
        r = x;
        if ((RELU_EN != 0) && x[DATA_WIDTH-1]) begin
            r = '0;
        end
        m = r;
        if ((cnt != '0) && (acc > r)) begin
            m = acc;
        end
        close = in_fire && ((cnt == CW'(POOL - 1)) || s_axis.tlast);
    end

    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            cnt       <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (in_fire) begin
                if (close) begin
                    cnt      <= '0;
                    out_data <= m;
                    out_last <= s_axis.tlast;
                end else begin
                    acc <= m;
                    cnt <= cnt + CW'(1);
                end
            end
            // A new close reloads the slot in the same edge the old beat leaves.
            if (close) begin
                out_valid <= 1'b1;
            end else if (m_axis.tready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign m_axis.tdata  = out_data;
    assign m_axis.tlast  = out_last;
    assign m_axis.tvalid = out_valid;
    assign m_axis.tkeep  = '1;
endmodule

// File: tb/tb_relu_maxpool1d.sv
// Self-checking bench for relu_maxpool1d across several POOL/RELU_EN configurations.
module tb_relu_maxpool1d;
    localparam int NCFG = 5;
    localparam int DW   = 16;

    function automatic int pool_of(input int i);
        case (i)
            0, 1:    return 2;
            2:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic int relu_of(input int i);
        return (i == 1 || i == 4) ? 0 : 1;
    endfunction

    logic          clk = 1'b0;
    logic          rst;
    int            sel;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          in_valid;
    logic          out_ready;

    logic          s_ready_a [NCFG];
    logic          m_valid_a [NCFG];
    logic          m_last_a  [NCFG];
    logic [DW-1:0] m_data_a  [NCFG];
    logic [1:0]    m_keep_a  [NCFG];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < NCFG; g++) begin : cfg
            relu_maxpool1d_if #(.DATA_WIDTH(DW)) s_if ();
            relu_maxpool1d_if #(.DATA_WIDTH(DW)) m_if ();

            assign s_if.tdata   = in_data;
            assign s_if.tkeep   = 2'b01;
            assign s_if.tlast   = in_last;
            assign s_if.tvalid  = in_valid && (sel == g);
            assign m_if.tready  = out_ready;
            assign s_ready_a[g] = s_if.tready;
            assign m_valid_a[g] = m_if.tvalid;
            assign m_last_a[g]  = m_if.tlast;
            assign m_data_a[g]  = m_if.tdata;
            assign m_keep_a[g]  = m_if.tkeep;

            relu_maxpool1d #(
                .DATA_WIDTH(DW),
                .POOL(pool_of(g)),
                .RELU_EN(relu_of(g))
            ) dut (
                .AXIS_ACLK(clk),
                .AXIS_ARESET(rst),
                .s_axis(s_if.slave),
                .m_axis(m_if.master)
            );
        end
    endgenerate

    int            checks = 0;
    int            errors = 0;
    int            frame[$];
    logic [DW-1:0] stim_d[$];
    bit            stim_l[$];
    bit            stim_c[$];
    logic [DW:0]   exp_q[$];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    // Reference: split the frame into POOL-sized chunks and take the max of each.
    task automatic pushFrame(input int c);
        int p;
        int n;
        int best;
        int v;
        p = pool_of(c);
        n = frame.size();
        for (int i = 0; i < n; i++) begin
            stim_d.push_back(DW'(frame[i]));
            stim_l.push_back(i == n - 1);
            stim_c.push_back((i % p == p - 1) || (i == n - 1));
        end
        for (int s = 0; s < n; s += p) begin
            best = -100000;
            for (int j = s; j < s + p && j < n; j++) begin
                v = frame[j];
                if (relu_of(c) != 0 && v < 0) v = 0;
                if (v > best) best = v;
            end
            exp_q.push_back({(s + p >= n), DW'(best)});
        end
    endtask

    // mode 0: ready high, 1: ready 1,0,0,1 pattern, 2: random ready; gap != 0 adds valid bubbles
    task automatic applyStimulus(input int c, input int mode, input int gap);
        int            cyc;
        bit            hold_prev;
        bit            close_prev;
        bit            stuck;
        logic [DW-1:0] prev_d;
        logic          prev_l;
        sel        = c;
        cyc        = 0;
        hold_prev  = 0;
        close_prev = 0;
        stuck      = 0;
        prev_d     = '0;
        prev_l     = 1'b0;
        while ((stim_d.size() > 0 || exp_q.size() > 0) && cyc < 2000) begin
            in_valid = (stim_d.size() > 0) && (stuck || gap == 0 || $urandom_range(0, 3) != 0);
            if (stim_d.size() > 0) begin
                in_data = stim_d[0];
                in_last = stim_l[0];
            end else begin
                in_data = DW'($urandom);
                in_last = 1'b0;
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            checkOutput("s_ready_rule", 32'(s_ready_a[c]), 32'(!m_valid_a[c] || out_ready));
            if (hold_prev) begin
                checkOutput("hold_valid", 32'(m_valid_a[c]), 32'd1);
                checkOutput("hold_data", 32'(m_data_a[c]), 32'(prev_d));
                checkOutput("hold_last", 32'(m_last_a[c]), 32'(prev_l));
            end
            if (close_prev) checkOutput("latency", 32'(m_valid_a[c]), 32'd1);
            if (m_valid_a[c] && out_ready) begin
                checkOutput("out_beat", {15'b0, m_last_a[c], m_data_a[c]},
                            (exp_q.size() > 0) ? {15'b0, exp_q.pop_front()} : 32'hFFFF_FFFF);
            end
            close_prev = 0;
            stuck      = in_valid && !s_ready_a[c];
            if (in_valid && s_ready_a[c]) begin
                close_prev = stim_c.pop_front();
                void'(stim_d.pop_front());
                void'(stim_l.pop_front());
            end
            hold_prev = m_valid_a[c] && !out_ready;
            prev_d    = m_data_a[c];
            prev_l    = m_last_a[c];
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        checkOutput("drain_timeout", 32'(stim_d.size() + exp_q.size()), 32'd0);
        stim_d.delete();
        stim_l.delete();
        stim_c.delete();
        exp_q.delete();
    endtask

    initial begin
        rst       = 1'b1;
        sel       = 0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #12;
        for (int i = 0; i < NCFG; i++) begin
            checkOutput("rst_valid", 32'(m_valid_a[i]), 32'd0);
            checkOutput("rst_data", 32'(m_data_a[i]), 32'd0);
            checkOutput("rst_last", 32'(m_last_a[i]), 32'd0);
            checkOutput("rst_keep", 32'(m_keep_a[i]), 32'd3);
            checkOutput("rst_s_ready", 32'(s_ready_a[i]), 32'd1);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        frame = '{0, 0, 0, 0, 1, 6, 0, 2, 7, 0};
        pushFrame(0);
        applyStimulus(0, 0, 0);

        frame = '{-5, -3, 4, -1};
        pushFrame(0);
        applyStimulus(0, 0, 0);
        pushFrame(1);
        applyStimulus(1, 0, 0);

        frame = '{9, 2, 5, 8, 1};
        pushFrame(2);
        frame = '{3, 3, 3};
        pushFrame(2);
        applyStimulus(2, 0, 0);

        frame = '{1, 2, 3, 4, 5, 6, 7, 8};
        pushFrame(0);
        applyStimulus(0, 1, 0);

        // Reset while a pooled beat is held, then again with 7 sitting in the accumulator.
        sel       = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'd9;
        in_last   = 1'b0;
        @(posedge clk);
        #1;
        in_data = 16'd2;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("pre_rst_valid", 32'(m_valid_a[0]), 32'd1);
        checkOutput("pre_rst_data", 32'(m_data_a[0]), 32'd9);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_valid", 32'(m_valid_a[0]), 32'd0);
        checkOutput("async_rst_data", 32'(m_data_a[0]), 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst2_valid", 32'(m_valid_a[0]), 32'd0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        frame = '{3, 1};
        pushFrame(0);
        applyStimulus(0, 0, 0);

        frame = '{32767, -32768, 1};
        pushFrame(3);
        applyStimulus(3, 0, 0);
        pushFrame(4);
        applyStimulus(4, 0, 0);

        for (int c = 0; c < NCFG; c++) begin
            for (int k = 0; k < 6; k++) begin
                frame.delete();
                for (int i = 0; i < int'($urandom_range(1, 9)); i++) begin
                    if ($urandom_range(0, 1) == 0) frame.push_back(int'($urandom_range(0, 8)) - 4);
                    else frame.push_back(int'($urandom_range(0, 65535)) - 32768);
                end
                pushFrame(c);
            end
            applyStimulus(c, 2, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
